hack_fetch_unit: RTL and testbench

- Instruction-fetch and jump-resolution stage of the Hack CPU datapath.
- Holds the program counter and issues one ROM read at a time over a req/ack handshake.
- Presents each fetched instruction to decode over a valid/ready handshake.
- Takes the ALU flags and the instruction's jump bits back from execute and picks the next PC: A-register target or PC+1.
- Feeds the decode/execute stage and consumes the OR-reduced jump condition built from the gate library.

---
 rtl/hack_fetch_unit.sv | 83 ++++++++
 tb/tb_hack_fetch_unit.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/hack_fetch_unit.sv
// Hack CPU fetch stage: holds the PC, issues one ROM read at a time, hands the word to decode,
// then resolves the jump condition from execute to pick the next PC.
module hack_fetch_unit #(
  parameter int unsigned      WIDTH      = 16,
  parameter logic [WIDTH-1:0] RESET_ADDR = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  output logic             rom_req,
  output logic [WIDTH-1:0] rom_addr,
  input  logic             rom_ack,
  input  logic [WIDTH-1:0] rom_data,
  output logic [WIDTH-1:0] instr,
  output logic [WIDTH-1:0] instr_pc,
  output logic             instr_valid,
  input  logic             instr_ready,
  input  logic             jmp_valid,
  input  logic [2:0]       jmp_bits,
  input  logic             zr,
  input  logic             ng,
  input  logic [WIDTH-1:0] a_reg,
  output logic [WIDTH-1:0] taken_cnt
);

  typedef enum logic [1:0] {
    StFetchArm,
    StFetch,
    StHold,
    StResolve
  } state_e;

  state_e           state_q;
  logic [WIDTH-1:0] pc_q;
  logic             take;

  // j1 = lt, j2 = eq, j3 = gt; zr & ng together is evaluated literally.
  assign take = (jmp_bits[2] & ng) | (jmp_bits[1] & zr) | (jmp_bits[0] & ~ng & ~zr);

  assign rom_addr = pc_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StFetchArm;
      pc_q        <= RESET_ADDR;
      rom_req     <= 1'b0;
      instr       <= '0;
      instr_pc    <= '0;
      instr_valid <= 1'b0;
      taken_cnt   <= '0;
    end else begin
      unique case (state_q)
        StFetchArm: begin
          rom_req <= 1'b1;
          state_q <= StFetch;
        end
        StFetch: begin
          if (rom_ack) begin
            instr       <= rom_data;
            instr_pc    <= pc_q;
            rom_req     <= 1'b0;
            instr_valid <= 1'b1;
            state_q     <= StHold;
          end
        end
        StHold: begin
          if (instr_ready) begin
            instr_valid <= 1'b0;
            state_q     <= StResolve;
          end
        end
        StResolve: begin
          if (jmp_valid) begin
            pc_q      <= take ? a_reg : pc_q + WIDTH'(1);
            taken_cnt <= taken_cnt + WIDTH'(take);
            state_q   <= StFetchArm;
          end
        end
        default: state_q <= StFetchArm;
      endcase
    end
  end

endmodule

// File: tb/tb_hack_fetch_unit.sv
// Directed bench for hack_fetch_unit; a second 4-bit instance shares the stimulus so the
// taken-jump counter wrap is reachable in a few hundred cycles.
module tb_hack_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        rom_req;
  logic [15:0] rom_addr;
  logic        rom_ack;
  logic [15:0] rom_data;
  logic [15:0] instr;
  logic [15:0] instr_pc;
  logic        instr_valid;
  logic        instr_ready;
  logic        jmp_valid;
  logic [2:0]  jmp_bits;
  logic        zr;
  logic        ng;
  logic [15:0] a_reg;
  logic [15:0] taken_cnt;

  logic        s_rom_req;
  logic [3:0]  s_rom_addr;
  logic [3:0]  s_instr;
  logic [3:0]  s_instr_pc;
  logic        s_instr_valid;
  logic [3:0]  s_taken_cnt;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  hack_fetch_unit #(.WIDTH(16), .RESET_ADDR(16'h0000)) dut (
    .clk(clk), .rst_n(rst_n), .rom_req(rom_req), .rom_addr(rom_addr), .rom_ack(rom_ack),
    .rom_data(rom_data), .instr(instr), .instr_pc(instr_pc), .instr_valid(instr_valid),
    .instr_ready(instr_ready), .jmp_valid(jmp_valid), .jmp_bits(jmp_bits), .zr(zr), .ng(ng),
    .a_reg(a_reg), .taken_cnt(taken_cnt)
  );

  hack_fetch_unit #(.WIDTH(4), .RESET_ADDR(4'h0)) dut_small (
    .clk(clk), .rst_n(rst_n), .rom_req(s_rom_req), .rom_addr(s_rom_addr), .rom_ack(rom_ack),
    .rom_data(rom_data[3:0]), .instr(s_instr), .instr_pc(s_instr_pc),
    .instr_valid(s_instr_valid), .instr_ready(instr_ready), .jmp_valid(jmp_valid),
    .jmp_bits(jmp_bits), .zr(zr), .ng(ng), .a_reg(a_reg[3:0]), .taken_cnt(s_taken_cnt)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  // Entered on a negedge; returns on the negedge where the word is in HOLD.
  task automatic do_fetch(input int lat, input logic [15:0] data);
    int n = 0;
    while (rom_req !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (rom_req !== 1'b1) check("req_timeout", {31'd0, rom_req}, 32'd1);
    repeat (lat) @(negedge clk);
    rom_data = data;
    rom_ack  = 1'b1;
    @(negedge clk);
    rom_ack  = 1'b0;
  endtask

  task automatic handshake();
    instr_ready = 1'b1;
    @(negedge clk);
    instr_ready = 1'b0;
    check("hs_valid_drop", {31'd0, instr_valid}, 32'd0);
  endtask

  // Returns on the negedge where the next fetch has rom_req high.
  task automatic resolve(input logic [2:0] bits, input logic z, input logic n,
                         input logic [15:0] a);
    jmp_bits  = bits;
    zr        = z;
    ng        = n;
    a_reg     = a;
    jmp_valid = 1'b1;
    @(negedge clk);
    jmp_valid = 1'b0;
    check("arm_req_low", {31'd0, rom_req}, 32'd0);
    @(negedge clk);
  endtask

  task automatic run_insn(input string tag, input logic [15:0] pc, input int lat,
                          input logic [2:0] bits, input logic z, input logic n,
                          input logic [15:0] a, input logic [15:0] next_pc,
                          input logic [15:0] cnt);
    check({tag, "_addr"}, {16'd0, rom_addr}, {16'd0, pc});
    do_fetch(lat, 16'h1000 + pc);
    check({tag, "_instr"}, {16'd0, instr}, {16'd0, 16'h1000 + pc});
    check({tag, "_ipc"}, {16'd0, instr_pc}, {16'd0, pc});
    check({tag, "_valid"}, {31'd0, instr_valid}, 32'd1);
    handshake();
    resolve(bits, z, n, a);
    check({tag, "_req"}, {31'd0, rom_req}, 32'd1);
    check({tag, "_next"}, {16'd0, rom_addr}, {16'd0, next_pc});
    check({tag, "_cnt"}, {16'd0, taken_cnt}, {16'd0, cnt});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; rom_ack = 1'b0; rom_data = '0; instr_ready = 1'b0;
    jmp_valid = 1'b0; jmp_bits = '0; zr = 1'b0; ng = 1'b0; a_reg = '0;
    repeat (3) @(negedge clk);
    check("rst_req", {31'd0, rom_req}, 32'd0);
    check("rst_addr", {16'd0, rom_addr}, 32'd0);
    check("rst_valid", {31'd0, instr_valid}, 32'd0);
    check("rst_cnt", {16'd0, taken_cnt}, 32'd0);
    rst_n = 1'b1;
    #1 check("arm_req", {31'd0, rom_req}, 32'd0);
    @(negedge clk);
    check("first_req", {31'd0, rom_req}, 32'd1);

    run_insn("seq0", 16'h0000, 0, 3'b000, 1'b0, 1'b0, 16'h0000, 16'h0001, 16'd0);
    run_insn("seq1", 16'h0001, 3, 3'b000, 1'b0, 1'b0, 16'h0000, 16'h0002, 16'd0);
    run_insn("seq2", 16'h0002, 0, 3'b000, 1'b0, 1'b0, 16'h0000, 16'h0003, 16'd0);
    run_insn("seq3", 16'h0003, 1, 3'b000, 1'b1, 1'b1, 16'h0077, 16'h0004, 16'd0);
    run_insn("seq4", 16'h0004, 0, 3'b000, 1'b0, 1'b0, 16'h0000, 16'h0005, 16'd0);
    run_insn("jeq", 16'h0005, 0, 3'b010, 1'b1, 1'b0, 16'h0040, 16'h0040, 16'd1);

    // Backpressure with spurious jmp_valid in HOLD, then spurious rom_ack in RESOLVE.
    do_fetch(0, 16'h1040);
    for (int i = 0; i < 5; i++) begin
      jmp_bits = 3'b111; a_reg = 16'h0077; jmp_valid = 1'b1;
      @(negedge clk);
      check("bp_valid", {31'd0, instr_valid}, 32'd1);
      check("bp_instr", {16'd0, instr}, 32'h1040);
      check("bp_ipc", {16'd0, instr_pc}, 32'h0040);
    end
    jmp_valid = 1'b0;
    check("bp_addr", {16'd0, rom_addr}, 32'h0040);
    check("bp_cnt", {16'd0, taken_cnt}, 32'd1);
    handshake();
    rom_data = 16'hDEAD; rom_ack = 1'b1;
    repeat (2) @(negedge clk);
    rom_ack = 1'b0;
    check("res_ack_req", {31'd0, rom_req}, 32'd0);
    check("res_ack_instr", {16'd0, instr}, 32'h1040);
    check("res_ack_valid", {31'd0, instr_valid}, 32'd0);
    resolve(3'b001, 1'b0, 1'b1, 16'h0099);
    check("jgt_next", {16'd0, rom_addr}, 32'h0041);
    check("jgt_cnt", {16'd0, taken_cnt}, 32'd1);

    run_insn("jmp", 16'h0041, 2, 3'b111, 1'b0, 1'b0, 16'h1234, 16'h1234, 16'd2);
    run_insn("lt_both", 16'h1234, 0, 3'b100, 1'b1, 1'b1, 16'h0050, 16'h0050, 16'd3);
    run_insn("ge_neg", 16'h0050, 0, 3'b011, 1'b0, 1'b1, 16'h0099, 16'h0051, 16'd3);
    run_insn("to_top", 16'h0051, 0, 3'b111, 1'b0, 1'b0, 16'hFFFF, 16'hFFFF, 16'd4);
    run_insn("pc_wrap", 16'hFFFF, 0, 3'b000, 1'b0, 1'b0, 16'h0000, 16'h0000, 16'd4);

    for (int k = 0; k < 12; k++) begin
      run_insn("loop", (k == 0) ? 16'h0000 : 16'h0040, 0, 3'b111, 1'b0, 1'b0, 16'h0040,
               16'h0040, 16'(5 + k));
      if (k == 10) check("small_cnt_max", {28'd0, s_taken_cnt}, 32'hF);
      if (k == 11) check("small_cnt_wrap", {28'd0, s_taken_cnt}, 32'h0);
    end

    // Async reset between edges while fetching at 0x40.
    #2 rst_n = 1'b0;
    #1;
    check("areset_req", {31'd0, rom_req}, 32'd0);
    check("areset_addr", {16'd0, rom_addr}, 32'd0);
    check("areset_cnt", {16'd0, taken_cnt}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    rom_data = 16'hBEEF; rom_ack = 1'b1;
    @(negedge clk);
    rom_ack = 1'b0;
    check("late_ack_req", {31'd0, rom_req}, 32'd1);
    check("late_ack_valid", {31'd0, instr_valid}, 32'd0);
    check("late_ack_addr", {16'd0, rom_addr}, 32'd0);
    do_fetch(0, 16'h1000);
    check("restart_instr", {16'd0, instr}, 32'h1000);
    check("restart_ipc", {16'd0, instr_pc}, 32'h0000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
